// File: rtl/uart_host_ctrl.sv
// uart_host_ctrl: polls UART status, drains RX bytes, round-robin TX arbitration.
// Define UART_HOST_CTRL_ERR_DROP_EN to drop framing/parity-errored RX bytes.
`timescale 1ns/1ps
module uart_host_ctrl #(
  parameter int NREQ    = 4,
  parameter int HOLDOFF = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ack,
  input  logic [7:0]        uart_data_out,
  output logic              read_status,
  output logic              read_data,
  output logic              tx_load,
  output logic [7:0]        tx_data,
  output logic              rx_valid,
  output logic [7:0]        rx_byte,
  output logic [2:0]        rx_err,
  output logic [7:0]        drop_cnt
);

  localparam int RW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
  localparam logic [RW-1:0] RR_RST = RW'(NREQ - 1);
  localparam logic [HW-1:0] HOLD_LAST = HW'(HOLDOFF - 1);

  typedef enum logic [2:0] {
    S_POLL,
    S_EVAL,
    S_RD,
    S_LOAD,
    S_HOLD
  } state_e;

  state_e state_q, state_d;
  logic [4:0]    stat_q, stat_d;
  logic [RW-1:0] rr_q, rr_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          rx_valid_q, rx_valid_d;
  logic [7:0]    rx_byte_q, rx_byte_d;
  logic [2:0]    rx_err_q, rx_err_d;
  logic [7:0]    drop_q, drop_d;

  logic [RW-1:0] grant;
  logic [RW-1:0] sel;
  logic          grant_ok;
  logic          drop_hit;
  logic          unused_hi;

  assign unused_hi = ^uart_data_out[7:5];

`ifdef UART_HOST_CTRL_ERR_DROP_EN
  assign drop_hit = stat_q[3] | stat_q[2];
`else
  assign drop_hit = 1'b0;
`endif

  // First valid requester after the last winner, wrapping at NREQ.
  always_comb begin
    grant    = '0;
    sel      = '0;
    grant_ok = 1'b0;
    for (int k = 1; k <= NREQ; k++) begin
      sel = RW'((int'(rr_q) + k) % NREQ);
      if (!grant_ok && req_valid[sel]) begin
        grant_ok = 1'b1;
        grant    = sel;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    stat_d      = stat_q;
    rr_d        = rr_q;
    hold_d      = hold_q;
    rx_valid_d  = 1'b0;
    rx_byte_d   = rx_byte_q;
    rx_err_d    = rx_err_q;
    drop_d      = drop_q;
    read_status = 1'b0;
    read_data   = 1'b0;
    tx_load     = 1'b0;
    tx_data     = 8'h00;
    req_ack     = '0;
    unique case (state_q)
      S_POLL: begin
        read_status = 1'b1;
        stat_d      = uart_data_out[4:0];
        state_d     = S_EVAL;
      end
      S_EVAL: begin
        if (stat_q[0]) begin
          state_d = S_RD;
        end else if (stat_q[1] && |req_valid) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_POLL;
        end
      end
      S_RD: begin
        read_data = 1'b1;
        state_d   = S_POLL;
        if (drop_hit) begin
          if (drop_q != 8'hFF) begin
            drop_d = drop_q + 8'd1;
          end
        end else begin
          rx_valid_d = 1'b1;
          rx_byte_d  = uart_data_out;
          rx_err_d   = stat_q[4:2];
        end
      end
      S_LOAD: begin
        if (grant_ok) begin
          tx_load        = 1'b1;
          tx_data        = req_data[8*int'(grant) +: 8];
          req_ack[grant] = 1'b1;
          rr_d           = grant;
          hold_d         = HOLD_LAST;
          state_d        = S_HOLD;
        end else begin
          state_d = S_POLL;
        end
      end
      S_HOLD: begin
        if (hold_q == '0) begin
          state_d = S_POLL;
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      default: state_d = S_POLL;
    endcase
    // No strobe may leak out while reset is held.
    if (reset) begin
      read_status = 1'b0;
      read_data   = 1'b0;
      tx_load     = 1'b0;
      tx_data     = 8'h00;
      req_ack     = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_POLL;
      stat_q     <= '0;
      rr_q       <= RR_RST;
      hold_q     <= '0;
      rx_valid_q <= 1'b0;
      rx_byte_q  <= 8'h00;
      rx_err_q   <= 3'b000;
      drop_q     <= 8'h00;
    end else begin
      state_q    <= state_d;
      stat_q     <= stat_d;
      rr_q       <= rr_d;
      hold_q     <= hold_d;
      rx_valid_q <= rx_valid_d;
      rx_byte_q  <= rx_byte_d;
      rx_err_q   <= rx_err_d;
      drop_q     <= drop_d;
    end
  end

  assign rx_valid = rx_valid_q;
  assign rx_byte  = rx_byte_q;
  assign rx_err   = rx_err_q;
  assign drop_cnt = drop_q;

endmodule

// File: tb/tb_uart_host_ctrl.sv
// tb_uart_host_ctrl: scoreboard bench with a behavioural UART and requesters.
// Honours UART_HOST_CTRL_ERR_DROP_EN for the expected drop behaviour.
`timescale 1ns/1ps
module tb_uart_host_ctrl;
  localparam int NREQ    = 4;
  localparam int HOLDOFF = 2;
`ifdef UART_HOST_CTRL_ERR_DROP_EN
  localparam bit DROP = 1'b1;
`else
  localparam bit DROP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ack;
  logic [7:0]        uart_data_out;
  logic              read_status, read_data, tx_load;
  logic [7:0]        tx_data;
  logic              rx_valid;
  logic [7:0]        rx_byte;
  logic [2:0]        rx_err;
  logic [7:0]        drop_cnt;

  // Behavioural UART: one pending RX byte, TX engine busy for a while.
  logic       rx_pend = 1'b0;
  logic [7:0] rx_b = 8'h00;
  logic [2:0] rx_e = 3'b000;
  logic       tx_rdy = 1'b1;
  int         tx_busy = 0;
  int         busy_max = 6;

  assign uart_data_out = read_data ? rx_b
                       : {3'b000, rx_e, tx_rdy, rx_pend};

  int cmp = 0;
  int bad = 0;
  int cyc = 0;
  logic [10:0] rx_q[$];
  logic [7:0]  exp_tx[NREQ][$];
  int          ack_log[$];
  int          tl_cyc[$];
  int          exp_drop = 0;
  int          ref_rr = NREQ - 1;
  int          t_rxv = -1;
  int          t_tl = -1;
  logic        rand_en = 1'b0;
  logic [NREQ-1:0] refill = '0;
  logic        last_rs = 1'b0;
  logic        last_ok = 1'b0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  uart_host_ctrl #(.NREQ(NREQ), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk),
    .reset(reset),
    .req_valid(req_valid),
    .req_data(req_data),
    .req_ack(req_ack),
    .uart_data_out(uart_data_out),
    .read_status(read_status),
    .read_data(read_data),
    .tx_load(tx_load),
    .tx_data(tx_data),
    .rx_valid(rx_valid),
    .rx_byte(rx_byte),
    .rx_err(rx_err),
    .drop_cnt(drop_cnt)
  );

  // Monitor: pops expectations whenever the DUT presents a result.
  always @(negedge clk) begin
    int g;
    int j;
    logic [10:0] e;
    logic [7:0] eb;
    logic [NREQ-1:0] ea;
    if (reset) begin
      ref_rr = NREQ - 1;
      cmp++;
      if ({read_status, read_data, tx_load, req_ack} != '0) begin
        bad++;
        $display("FAIL rst_strobe: got %b%b%b %b want 0",
                 read_status, read_data, tx_load, req_ack);
      end
    end
    if (read_status || read_data) begin
      cmp++;
      if (read_status && read_data) begin
        bad++;
        $display("FAIL rd_excl: read_status=1 read_data=1 want exclusive");
      end
    end
    if (rx_valid === 1'b1) begin
      t_rxv = cyc;
      cmp++;
      if (rx_q.size() == 0) begin
        bad++;
        $display("FAIL rx_extra: got byte %h err %b want none",
                 rx_byte, rx_err);
      end else begin
        e = rx_q.pop_front();
        if ({rx_err, rx_byte} !== e) begin
          bad++;
          $display("FAIL rx_data: got %b/%h want %b/%h",
                   rx_err, rx_byte, e[10:8], e[7:0]);
        end
      end
    end
    if (tx_load === 1'b1 || (req_ack != '0 && !reset)) begin
      t_tl = cyc;
      g = -1;
      for (int k = 1; k <= NREQ; k++) begin
        j = (ref_rr + k) % NREQ;
        if (g < 0 && req_valid[j]) g = j;
      end
      ea = '0;
      if (g >= 0) ea[g] = 1'b1;
      cmp++;
      if (g < 0 || req_ack !== ea || tx_load !== 1'b1) begin
        bad++;
        $display("FAIL tx_grant: got ack %b load %b want ack %b",
                 req_ack, tx_load, ea);
      end else begin
        eb = exp_tx[g].pop_front();
        cmp++;
        if (tx_data !== eb) begin
          bad++;
          $display("FAIL tx_data: got %h want %h (req %0d)",
                   tx_data, eb, g);
        end
        ack_log.push_back(g);
        tl_cyc.push_back(cyc);
        ref_rr = g;
      end
    end
  end

  task automatic offer(input int i);
    logic [7:0] b;
    b = 8'($urandom);
    req_data[8*i +: 8] = b;
    req_valid[i] = 1'b1;
    exp_tx[i].push_back(b);
  endtask

  task automatic inject(input logic [7:0] b, input logic [2:0] e);
    rx_pend = 1'b1;
    rx_b = b;
    rx_e = e;
    if (DROP && (e[1] || e[0])) begin
      if (exp_drop < 255) exp_drop++;
    end else begin
      rx_q.push_back({e, b});
    end
  endtask

  task automatic tick();
    logic rd, tl;
    logic [NREQ-1:0] ak;
    @(negedge clk);
    rd = read_data;
    tl = tx_load;
    ak = req_ack;
    last_rs = read_status;
    last_ok = tx_rdy && !rx_pend;
    @(posedge clk);
    #1;
    if (rd) begin
      rx_pend = 1'b0;
      rx_e = 3'b000;
    end
    if (tl) begin
      tx_rdy = 1'b0;
      tx_busy = $urandom_range(1, busy_max);
    end else if (tx_busy > 0) begin
      tx_busy--;
      if (tx_busy == 0) tx_rdy = 1'b1;
    end
    for (int i = 0; i < NREQ; i++) begin
      if (ak[i]) begin
        req_valid[i] = 1'b0;
        if (refill[i]) offer(i);
      end
    end
    if (rand_en) begin
      if (!rx_pend && $urandom_range(0, 3) == 0) begin
        if ($urandom_range(0, 2) == 0) inject(8'($urandom), 3'($urandom));
        else inject(8'($urandom), 3'b000);
      end
      for (int i = 0; i < NREQ; i++) begin
        if (!req_valid[i] && $urandom_range(0, 5) == 0) offer(i);
      end
    end
  endtask

  function automatic bit txq_empty();
    for (int i = 0; i < NREQ; i++) begin
      if (exp_tx[i].size() != 0) return 1'b0;
    end
    return 1'b1;
  endfunction

  task automatic drain();
    bit ok;
    rand_en = 1'b0;
    ok = 1'b0;
    for (int n = 0; n < 2000 && !ok; n++) begin
      tick();
      ok = rx_q.size() == 0 && req_valid == '0 && !rx_pend && txq_empty();
    end
    cmp++;
    if (!ok) begin
      bad++;
      $display("FAIL drain: rxq %0d req %b want all empty",
               rx_q.size(), req_valid);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (3) tick();
    @(negedge clk);
    cmp++;
    if ({read_status, read_data, tx_load, tx_data, req_ack,
         rx_valid, rx_byte, rx_err, drop_cnt} != '0) begin
      bad++;
      $display("FAIL rst_vals: got rs%b rd%b tl%b td%h ak%b rv%b rb%h re%b dc%h want 0",
               read_status, read_data, tx_load, tx_data, req_ack,
               rx_valid, rx_byte, rx_err, drop_cnt);
    end
    rx_pend = 1'b0;
    rx_e = 3'b000;
    tx_rdy = 1'b1;
    tx_busy = 0;
    req_valid = '0;
    refill = '0;
    exp_drop = 0;
    rx_q.delete();
    for (int i = 0; i < NREQ; i++) exp_tx[i].delete();
    ack_log.delete();
    tl_cyc.delete();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_acks(input int n);
    for (int w = 0; w < 300 && ack_log.size() < n; w++) tick();
    cmp++;
    if (ack_log.size() < n) begin
      bad++;
      $display("FAIL ack_wait: got %0d acks want %0d", ack_log.size(), n);
    end
  endtask

  task automatic chk(input string nm, input int got, input int want);
    cmp++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0d want %0d", nm, got, want);
    end
  endtask

  initial begin
    int c0;
    int w;
    bit hit;

    // RX beats TX; both latencies from the first POLL cycle.
    do_reset();
    inject(8'h5A, 3'b000);
    offer(0);
    c0 = cyc;
    reset = 1'b0;
    drain();
    chk("rx_latency", t_rxv, c0 + 3);
    chk("tx_after_rx", t_tl, c0 + 5);
    chk("rx_byte_hold", int'(rx_byte), 'h5A);

    // Round-robin with requesters 1 and 3 permanently pending.
    do_reset();
    busy_max = 1;
    refill = 4'b1010;
    offer(1);
    offer(3);
    reset = 1'b0;
    wait_acks(3);
    refill = '0;
    drain();
    busy_max = 6;
    if (ack_log.size() >= 3) begin
      chk("rr_first", ack_log[0], 1);
      chk("rr_second", ack_log[1], 3);
      chk("rr_third", ack_log[2], 1);
      chk("holdoff_gap", tl_cyc[1] - tl_cyc[0], HOLDOFF + 3);
    end

    // Reset landing in LOAD: no strobe, pointer back to NREQ-1.
    do_reset();
    offer(0);
    reset = 1'b0;
    wait_acks(1);
    offer(0);
    offer(2);
    hit = 1'b0;
    for (int n = 0; n < 60 && !hit; n++) begin
      tick();
      hit = last_rs && last_ok;
    end
    chk("poll_found", int'(hit), 1);
    tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rst_load_tx", int'(tx_load), 0);
    chk("rst_load_ack", int'(req_ack), 0);
    @(posedge clk);
    #1;
    tick();
    tick();
    reset = 1'b0;
    wait_acks(3);
    drain();
    if (ack_log.size() >= 3) begin
      chk("rst_rr_a", ack_log[1], 0);
      chk("rst_rr_b", ack_log[2], 2);
    end

    // Errored bytes: OVF alone passes, F_ERR/P_ERR drop when enabled.
    do_reset();
    reset = 1'b0;
    inject(8'h77, 3'b100);
    drain();
    inject(8'hC3, 3'b010);
    drain();
    chk("drop_one", int'(drop_cnt), DROP ? 1 : 0);
    for (int n = 0; n < 300; n++) begin
      w = 0;
      while (rx_pend && w < 50) begin
        tick();
        w++;
      end
      inject(8'($urandom), n[0] ? 3'b010 : 3'b001);
    end
    drain();
    chk("drop_sat", int'(drop_cnt), DROP ? 255 : 0);

    // Randomised traffic against the reference model.
    do_reset();
    reset = 1'b0;
    rand_en = 1'b1;
    repeat (3000) tick();
    drain();
    chk("drop_rand", int'(drop_cnt), exp_drop);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, bad);
    $finish;
  end

endmodule
